div_iter_unit: RTL

- Iterative radix-2 restoring divider for the EX stage. Serves DIV and DIVU.
- While a division is in progress it raises stallreq_for_ex. The stall controller turns that request into a freeze of the fetch, decode and execute stages.
- Delivers {remainder, quotient} for the HI/LO write path once the result is ready.

---
 rtl/div_iter_unit_if.sv | 23 ++
 rtl/div_iter_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/div_iter_unit_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
interface div_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic                 div_start;
  logic                 signed_div;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 annul;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 stallreq_for_ex;

  modport master (
    output div_start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stallreq_for_ex
  );

  modport slave (
    input  div_start, signed_div, opdata1, opdata2, annul,
    output result, ready, stallreq_for_ex
  );
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign correction applied when the last bit is produced.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  div_iter_unit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BYZERO = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   dvd_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   rem_r;
  logic               sdiv_r;
  logic               sign1_r;
  logic               sign2_r;
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;

  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   dvd_nxt_s;
  logic               quo_bit_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
    logic [WIDTH-1:0] r;
    if (c) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // One restoring step plus the sign-corrected result of that step.
  // rem_r[WIDTH-1] is always 0 before a shift: after k steps rem < 2^k.
  always_comb begin
    trial_s = {1'b0, rem_r[WIDTH-2:0], dvd_r[WIDTH-1]} - {1'b0, dvs_r};
    if (!trial_s[WIDTH]) begin
      rem_nxt_s = trial_s[WIDTH-1:0];
      quo_bit_s = 1'b1;
    end else begin
      rem_nxt_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
      quo_bit_s = 1'b0;
    end
    dvd_nxt_s = {dvd_r[WIDTH-2:0], quo_bit_s};
    quo_fix_s = neg_if(dvd_nxt_s, sdiv_r & (sign1_r ^ sign2_r));
    rem_fix_s = neg_if(rem_nxt_s, sdiv_r & sign1_r);
  end

  // Sequencer, datapath registers and registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      dvd_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      sdiv_r   <= 1'b0;
      sign1_r  <= 1'b0;
      sign2_r  <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      ready_r  <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      if (bus.annul) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.div_start) begin
              sdiv_r  <= bus.signed_div;
              sign1_r <= bus.opdata1[WIDTH-1];
              sign2_r <= bus.opdata2[WIDTH-1];
              dvd_r   <= neg_if(bus.opdata1, bus.signed_div & bus.opdata1[WIDTH-1]);
              dvs_r   <= neg_if(bus.opdata2, bus.signed_div & bus.opdata2[WIDTH-1]);
              rem_r   <= {WIDTH{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
              if (bus.opdata2 == {WIDTH{1'b0}}) begin
                state_r <= ST_BYZERO;
              end else begin
                state_r <= ST_ON;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_BYZERO: begin
            state_r <= ST_END;
            ready_r <= 1'b1;
          end
          ST_ON: begin
            rem_r <= rem_nxt_s;
            dvd_r <= dvd_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
              state_r  <= ST_END;
              ready_r  <= 1'b1;
              result_r <= {rem_fix_s, quo_fix_s};
            end else begin
              state_r <= ST_ON;
            end
          end
          ST_END: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.result          = result_r;
  assign bus.ready           = ready_r;
  assign bus.stallreq_for_ex = bus.div_start & ~ready_r;

endmodule
